cross_bar_rtn: RTL and testbench

CROSS_BAR_RTN -- requirements
Module: cross_bar_rtn

---
 rtl/cross_bar_rtn.sv | 156 +++++++++++++++
 tb/tb_cross_bar_rtn.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cross_bar_rtn.sv
// Return crossbar: four memory banks to three cache channels, with a round-robin arbiter and FIFO per channel.
// Optional macro CROSS_BAR_RTN_ERR_EN enables the sticky illegal-channel error flag.
module cross_bar_rtn #(
  parameter int RTN_FIFO_DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         bank0_xbar_rtn_valid_i,
  input  logic         bank1_xbar_rtn_valid_i,
  input  logic         bank2_xbar_rtn_valid_i,
  input  logic         bank3_xbar_rtn_valid_i,
  output logic         bank0_xbar_rtn_ready_o,
  output logic         bank1_xbar_rtn_ready_o,
  output logic         bank2_xbar_rtn_ready_o,
  output logic         bank3_xbar_rtn_ready_o,
  input  logic [1:0]   bank0_xbar_rtn_ch_id_i,
  input  logic [1:0]   bank1_xbar_rtn_ch_id_i,
  input  logic [1:0]   bank2_xbar_rtn_ch_id_i,
  input  logic [1:0]   bank3_xbar_rtn_ch_id_i,
  input  logic [127:0] bank0_xbar_rtn_data_i,
  input  logic [127:0] bank1_xbar_rtn_data_i,
  input  logic [127:0] bank2_xbar_rtn_data_i,
  input  logic [127:0] bank3_xbar_rtn_data_i,
  output logic         mcash_ch0_rtn_valid_o,
  output logic         mcash_ch1_rtn_valid_o,
  output logic         mcash_ch2_rtn_valid_o,
  input  logic         mcash_ch0_rtn_ready_i,
  input  logic         mcash_ch1_rtn_ready_i,
  input  logic         mcash_ch2_rtn_ready_i,
  output logic [127:0] mcash_ch0_rtn_data_o,
  output logic [127:0] mcash_ch1_rtn_data_o,
  output logic [127:0] mcash_ch2_rtn_data_o,
  output logic         xbar_rtn_err_o
);
  localparam int DATA_W = 128;
  localparam int NB     = 4;
  localparam int NC     = 3;
  localparam int AW     = $clog2(RTN_FIFO_DEPTH);
  localparam int CW     = AW + 1;

  logic [NB-1:0]     b_vld;
  logic [1:0]        b_ch   [NB];
  logic [DATA_W-1:0] b_data [NB];
  logic [NB-1:0]     discard;
  logic [NB-1:0]     rdy;
  logic [NC-1:0]     gnt_vld;
  logic [1:0]        gnt_idx [NC];
  logic [NC-1:0]     vld_p1;
  logic [NC-1:0]     ch_rdy;
  logic [DATA_W-1:0] data_p1 [NC];

  assign b_vld     = {bank3_xbar_rtn_valid_i, bank2_xbar_rtn_valid_i,
                      bank1_xbar_rtn_valid_i, bank0_xbar_rtn_valid_i};
  assign b_ch[0]   = bank0_xbar_rtn_ch_id_i;
  assign b_ch[1]   = bank1_xbar_rtn_ch_id_i;
  assign b_ch[2]   = bank2_xbar_rtn_ch_id_i;
  assign b_ch[3]   = bank3_xbar_rtn_ch_id_i;
  assign b_data[0] = bank0_xbar_rtn_data_i;
  assign b_data[1] = bank1_xbar_rtn_data_i;
  assign b_data[2] = bank2_xbar_rtn_data_i;
  assign b_data[3] = bank3_xbar_rtn_data_i;
  assign ch_rdy    = {mcash_ch2_rtn_ready_i, mcash_ch1_rtn_ready_i, mcash_ch0_rtn_ready_i};

  // Returns {found, bank}; scanning downward so the lowest offset from ptr wins.
  function automatic logic [2:0] rr_pick(input logic [NB-1:0] req, input logic [1:0] ptr);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = NB - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  for (genvar n = 0; n < NB; n++) begin : g_bank
    assign discard[n] = !rst_i && b_vld[n] && (b_ch[n] == 2'd3);
  end

  for (genvar c = 0; c < NC; c++) begin : g_ch
    logic [NB-1:0]     req;
    logic [2:0]        pick;
    logic [1:0]        ptr;
    logic              deq;
    logic [DATA_W-1:0] mem_p1 [RTN_FIFO_DEPTH];
    logic [AW-1:0]     wr_p1;
    logic [AW-1:0]     rd_p1;
    logic [CW-1:0]     cnt_p1;

    for (genvar n = 0; n < NB; n++) begin : g_req
      assign req[n] = b_vld[n] && (b_ch[n] == 2'(c));
    end

    assign pick       = rr_pick(req, ptr);
    // Full check uses the registered count only: a same-cycle pop does not open a slot.
    assign gnt_vld[c] = pick[2] && !rst_i && (cnt_p1 != CW'(RTN_FIFO_DEPTH));
    assign gnt_idx[c] = pick[1:0];
    assign deq        = vld_p1[c] && ch_rdy[c];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ptr    <= 2'd0;
        wr_p1  <= '0;
        rd_p1  <= '0;
        cnt_p1 <= '0;
      end else begin
        if (gnt_vld[c]) begin
          ptr   <= gnt_idx[c] + 2'd1;
          wr_p1 <= wr_p1 + AW'(1);
        end
        if (deq) rd_p1 <= rd_p1 + AW'(1);
        if (gnt_vld[c] && !deq)      cnt_p1 <= cnt_p1 + CW'(1);
        else if (!gnt_vld[c] && deq) cnt_p1 <= cnt_p1 - CW'(1);
      end
    end

    // ---- stage p1: FIFO storage, read at head ----
    always_ff @(posedge clk_i) begin
      if (gnt_vld[c]) mem_p1[wr_p1] <= b_data[gnt_idx[c]];
    end

    assign vld_p1[c]  = !rst_i && (cnt_p1 != '0);
    assign data_p1[c] = vld_p1[c] ? mem_p1[rd_p1] : '0;
  end

  always_comb begin
    rdy = discard;
    for (int c = 0; c < NC; c++) begin
      if (gnt_vld[c]) rdy[gnt_idx[c]] = 1'b1;
    end
  end

  assign bank0_xbar_rtn_ready_o = rdy[0];
  assign bank1_xbar_rtn_ready_o = rdy[1];
  assign bank2_xbar_rtn_ready_o = rdy[2];
  assign bank3_xbar_rtn_ready_o = rdy[3];
  assign mcash_ch0_rtn_valid_o  = vld_p1[0];
  assign mcash_ch1_rtn_valid_o  = vld_p1[1];
  assign mcash_ch2_rtn_valid_o  = vld_p1[2];
  assign mcash_ch0_rtn_data_o   = data_p1[0];
  assign mcash_ch1_rtn_data_o   = data_p1[1];
  assign mcash_ch2_rtn_data_o   = data_p1[2];

`ifdef CROSS_BAR_RTN_ERR_EN
  logic err;

  always_ff @(posedge clk_i) begin
    if (rst_i)         err <= 1'b0;
    else if (|discard) err <= 1'b1;
  end

  assign xbar_rtn_err_o = err;
`else
  assign xbar_rtn_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_cross_bar_rtn.sv
// Self-checking bench for cross_bar_rtn: directed scenarios plus random traffic against a queue-based channel model.
module tb_cross_bar_rtn;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   vld;
  logic [1:0]   ch  [4];
  logic [127:0] dat [4];
  logic [2:0]   crdy;
  wire          rdy0, rdy1, rdy2, rdy3;
  wire          cv0, cv1, cv2;
  wire  [127:0] cdat [3];
  wire          err;
  wire  [3:0]   rdy  = {rdy3, rdy2, rdy1, rdy0};
  wire  [2:0]   cvld = {cv2, cv1, cv0};

  int compared   = 0;
  int mismatched = 0;
  int sent;
  logic [3:0] last_rdy;

  // Reference model: one ordered queue and one round-robin start bank per channel.
  logic [127:0] mq [3][$];
  int           mptr [3];
  logic         merr;

  always #5 clk = ~clk;

  cross_bar_rtn #(.RTN_FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .bank0_xbar_rtn_valid_i(vld[0]), .bank1_xbar_rtn_valid_i(vld[1]),
    .bank2_xbar_rtn_valid_i(vld[2]), .bank3_xbar_rtn_valid_i(vld[3]),
    .bank0_xbar_rtn_ready_o(rdy0), .bank1_xbar_rtn_ready_o(rdy1),
    .bank2_xbar_rtn_ready_o(rdy2), .bank3_xbar_rtn_ready_o(rdy3),
    .bank0_xbar_rtn_ch_id_i(ch[0]), .bank1_xbar_rtn_ch_id_i(ch[1]),
    .bank2_xbar_rtn_ch_id_i(ch[2]), .bank3_xbar_rtn_ch_id_i(ch[3]),
    .bank0_xbar_rtn_data_i(dat[0]), .bank1_xbar_rtn_data_i(dat[1]),
    .bank2_xbar_rtn_data_i(dat[2]), .bank3_xbar_rtn_data_i(dat[3]),
    .mcash_ch0_rtn_valid_o(cv0), .mcash_ch1_rtn_valid_o(cv1), .mcash_ch2_rtn_valid_o(cv2),
    .mcash_ch0_rtn_ready_i(crdy[0]), .mcash_ch1_rtn_ready_i(crdy[1]), .mcash_ch2_rtn_ready_i(crdy[2]),
    .mcash_ch0_rtn_data_o(cdat[0]), .mcash_ch1_rtn_data_o(cdat[1]), .mcash_ch2_rtn_data_o(cdat[2]),
    .xbar_rtn_err_o(err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs with the model at negedge, advance the model, return 1 after posedge.
  task automatic cycle();
    logic [3:0]   erdy;
    logic [3:0]   disc;
    logic [2:0]   evld;
    logic [127:0] edat;
    int           win [3];
    int           n;
    @(negedge clk);
    erdy = '0;
    disc = '0;
    evld = '0;
    for (int c = 0; c < 3; c++) win[c] = -1;
    if (!rst) begin
      for (int b = 0; b < 4; b++)
        if (vld[b] && int'(ch[b]) == 3) disc[b] = 1'b1;
      for (int c = 0; c < 3; c++) begin
        evld[c] = (mq[c].size() != 0);
        if (mq[c].size() < DEPTH)
          for (int k = 0; k < 4; k++) begin
            n = (mptr[c] + k) % 4;
            if (win[c] < 0 && vld[n] && int'(ch[n]) == c) win[c] = n;
          end
      end
      erdy = disc;
      for (int c = 0; c < 3; c++) if (win[c] >= 0) erdy[win[c]] = 1'b1;
    end
    last_rdy = rdy;
    check("bank_ready", 128'(rdy), 128'(erdy));
    check("ch_valid", 128'(cvld), 128'(evld));
    for (int c = 0; c < 3; c++) begin
      edat = evld[c] ? mq[c][0] : 128'h0;
      check($sformatf("ch%0d_data", c), cdat[c], edat);
    end
    check("err_flag", 128'(err), 128'(merr));
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        mq[c].delete();
        mptr[c] = 0;
      end
      merr = 1'b0;
    end else begin
      for (int c = 0; c < 3; c++) if (evld[c] && crdy[c]) void'(mq[c].pop_front());
      for (int c = 0; c < 3; c++)
        if (win[c] >= 0) begin
          mq[c].push_back(dat[win[c]]);
          mptr[c] = (win[c] + 1) % 4;
        end
`ifdef CROSS_BAR_RTN_ERR_EN
      if (|disc) merr = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vld  = '0;
    crdy = 3'b111;
    for (int b = 0; b < 4; b++) begin
      ch[b]  = 2'd0;
      dat[b] = '0;
    end
  endtask

  initial begin
    for (int c = 0; c < 3; c++) mptr[c] = 0;
    merr = 1'b0;
    rst  = 1'b1;
    idle();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Single beat bank2 -> ch1
    vld[2] = 1'b1; ch[2] = 2'd1; dat[2] = 128'hA5;
    cycle();
    check("single_rdy", 128'(last_rdy), 128'(4'b0100));
    vld = '0;
    check("single_vld", 128'(cvld), 128'(3'b010));
    check("single_data", cdat[1], 128'hA5);
    cycle();
    check("single_once", 128'(cvld), 128'(3'b000));

    // All banks stream to ch0: rotating grants
    for (int b = 0; b < 4; b++) begin
      vld[b] = 1'b1; ch[b] = 2'd0; dat[b] = 128'h100 + 128'(b);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rr_order", 128'(last_rdy), 128'(4'b0001 << (i % 4)));
    end
    idle();
    cycle(); cycle(); cycle();

    // Backpressure on ch2 with three beats from bank1
    sent = 0;
    for (int i = 0; i < 10; i++) begin
      vld[1]  = (sent < 3);
      ch[1]   = 2'd2;
      dat[1]  = 128'h300 + 128'(sent);
      crdy[2] = (i >= 4);
      cycle();
      if (last_rdy[1] && sent < 3) sent++;
      if (i == 3) check("bp_held", 128'(sent), 128'(2));
    end
    check("bp_all", 128'(sent), 128'(3));
    idle();
    cycle(); cycle(); cycle();

    // Parallel grants to three channels
    vld = 4'b1011;
    ch[0] = 2'd0; ch[1] = 2'd1; ch[3] = 2'd2;
    dat[0] = 128'hC0; dat[1] = 128'hC1; dat[3] = 128'hC2;
    cycle();
    check("par_rdy", 128'(last_rdy), 128'(4'b1011));
    vld = '0;
    check("par_vld", 128'(cvld), 128'(3'b111));
    cycle();

    // Illegal channel id is swallowed
    vld[3] = 1'b1; ch[3] = 2'd3; dat[3] = 128'hDEAD;
    cycle();
    check("ill_rdy", 128'(last_rdy), 128'(4'b1000));
    check("ill_novld", 128'(cvld), 128'(3'b000));
`ifdef CROSS_BAR_RTN_ERR_EN
    check("ill_err", 128'(err), 128'(1));
`else
    check("ill_err", 128'(err), 128'(0));
`endif
    idle();
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int b = 0; b < 4; b++) begin
        vld[b] = 1'($urandom_range(0, 1));
        ch[b]  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        dat[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      crdy = 3'($urandom_range(0, 7));
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle(); cycle(); cycle();

    // Reset with ch1 full, then restart arbitration from bank0
    crdy = 3'b101;
    vld[1] = 1'b1; ch[1] = 2'd1; dat[1] = 128'h51;
    cycle();
    dat[1] = 128'h52;
    cycle();
    vld = '0;
    check("full_vld", 128'(cvld[1]), 128'(1));
    rst = 1'b1;
    vld = 4'b1111;
    for (int b = 0; b < 4; b++) begin
      ch[b] = 2'd1; dat[b] = 128'h600 + 128'(b);
    end
    cycle();
    rst = 1'b0;
    check("rst_vld", 128'(cvld), 128'(3'b000));
    check("rst_data", cdat[1], 128'h0);
    crdy = 3'b111;
    cycle();
    check("rst_first", 128'(last_rdy), 128'(4'b0001));
    idle();
    cycle(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
